// File: rtl/stroke_interpolator_pkg.sv
// Shared screen geometry, coordinate types and FSM encoding for the pen-stroke path.
// The geometry constants are the same ones map_cam, write_buffer and pixel_buffer use.
package stroke_interpolator_pkg;
  localparam int CW       = 10;
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int MAX_JUMP = 64;

  typedef logic [CW-1:0]        coord_t;
  typedef logic signed [CW+1:0] sdelta_t;

  localparam coord_t NO_BLOB = coord_t'(1023);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

  function automatic coord_t abs_diff(coord_t a, coord_t b);
    return (a >= b) ? coord_t'(a - b) : coord_t'(b - a);
  endfunction
endpackage

// File: rtl/stroke_interpolator_if.sv
// Camera-sample input and plotted-point valid/ready stream of the stroke interpolator.
interface stroke_interpolator_if;
  import stroke_interpolator_pkg::*;

  logic   sample;
  coord_t x_in;
  coord_t y_in;
  logic   pt_valid;
  logic   pt_ready;
  coord_t pt_x;
  coord_t pt_y;
  logic   busy;
  logic   dropped;

  modport master (output sample, x_in, y_in, pt_ready,
                  input  pt_valid, pt_x, pt_y, busy, dropped);
  modport slave  (input  sample, x_in, y_in, pt_ready,
                  output pt_valid, pt_x, pt_y, busy, dropped);
endinterface

// File: rtl/stroke_interpolator_line_stepper.sv
// Registered Bresenham core: load takes the first step from start, step advances one pixel.
// done_o is high while the held point equals the target; x_o/y_o only move on load/step.
module stroke_interpolator_line_stepper
  import stroke_interpolator_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  logic   single_i,
  input  logic   step_i,
  input  coord_t start_x_i,
  input  coord_t start_y_i,
  input  coord_t tgt_x_i,
  input  coord_t tgt_y_i,
  output coord_t x_o,
  output coord_t y_o,
  output logic   done_o
);
  coord_t  x_q, y_q, x_d, y_d, base_x, base_y;
  sdelta_t err_q, err_d, base_err, dx_q, dy_q, cdx, cdy, e2;
  logic    sxn_q, syn_q, csxn, csyn, done_q;

  always_comb begin
    base_x   = x_q;
    base_y   = y_q;
    base_err = err_q;
    cdx      = dx_q;
    cdy      = dy_q;
    csxn     = sxn_q;
    csyn     = syn_q;
    if (load_i) begin
      base_x   = start_x_i;
      base_y   = start_y_i;
      cdx      = sdelta_t'(abs_diff(tgt_x_i, start_x_i));
      cdy      = -sdelta_t'(abs_diff(tgt_y_i, start_y_i));
      base_err = cdx + cdy;
      csxn     = tgt_x_i < start_x_i;
      csyn     = tgt_y_i < start_y_i;
    end
    // The load path folds in the first step so the start point is never presented.
    e2    = base_err <<< 1;
    x_d   = base_x;
    y_d   = base_y;
    err_d = base_err;
    if (e2 >= cdy) begin
      err_d = err_d + cdy;
      x_d   = csxn ? base_x - coord_t'(1) : base_x + coord_t'(1);
    end
    if (e2 <= cdx) begin
      err_d = err_d + cdx;
      y_d   = csyn ? base_y - coord_t'(1) : base_y + coord_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      err_q  <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      sxn_q  <= 1'b0;
      syn_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (load_i && single_i) begin
      x_q    <= tgt_x_i;
      y_q    <= tgt_y_i;
      done_q <= 1'b1;
    end else if (load_i || step_i) begin
      x_q    <= x_d;
      y_q    <= y_d;
      err_q  <= err_d;
      dx_q   <= cdx;
      dy_q   <= cdy;
      sxn_q  <= csxn;
      syn_q  <= csyn;
      done_q <= (x_d == tgt_x_i) && (y_d == tgt_y_i);
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign done_o = done_q;
endmodule

// File: rtl/stroke_interpolator.sv
// Joins successive pen samples with Bresenham lines; first point 2 clk after the sample, 1 point/clk.
// Points hold under !pt_ready; samples arriving while busy are dropped. STROKE_DEADBAND_EN drops 1-pixel jitter.
module stroke_interpolator
  import stroke_interpolator_pkg::*;
(
  input logic             clk,
  input logic             reset,
  stroke_interpolator_if.slave bus
);
  localparam coord_t H_LIM = coord_t'(H_RES);
  localparam coord_t V_LIM = coord_t'(V_RES);
  localparam coord_t JUMP  = coord_t'(MAX_JUMP);

  state_t state_q, state_d;
  coord_t tx_q, ty_q, last_x_q, last_y_q, adx, ady, stp_x, stp_y;
  logic   have_last_q, dropped_q;
  logic   tgt_ok, far, same, jitter, accept, stp_done;
  logic   load, single, step, upd_last, pt_valid;

  assign adx    = abs_diff(tx_q, last_x_q);
  assign ady    = abs_diff(ty_q, last_y_q);
  assign tgt_ok = (tx_q < H_LIM) && (ty_q < V_LIM);
  assign far    = (adx > JUMP) || (ady > JUMP);
  assign same   = (adx == '0) && (ady == '0);
`ifdef STROKE_DEADBAND_EN
  assign jitter = have_last_q && (adx <= coord_t'(1)) && (ady <= coord_t'(1));
`else
  assign jitter = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.sample) state_d = S_SETUP;
      S_SETUP: begin
        if (!tgt_ok || jitter)       state_d = S_IDLE;
        else if (!have_last_q || far) state_d = S_DRAW;
        else if (same)                state_d = S_IDLE;
        else                          state_d = S_DRAW;
      end
      S_DRAW:  if (accept && stp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pt_valid = (state_q == S_DRAW);
    accept   = pt_valid && bus.pt_ready;
    load     = (state_q == S_SETUP) && (state_d == S_DRAW);
    single   = !have_last_q || far;
    step     = accept && !stp_done;
    upd_last = (state_q == S_SETUP) && tgt_ok && !jitter;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_q        <= '0;
      ty_q        <= '0;
      last_x_q    <= '0;
      last_y_q    <= '0;
      have_last_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      dropped_q <= bus.sample && (state_q != S_IDLE);
      if (state_q == S_IDLE && bus.sample) begin
        tx_q <= bus.x_in;
        ty_q <= bus.y_in;
      end
      if (state_q == S_SETUP && !tgt_ok) begin
        have_last_q <= 1'b0;
      end else if (upd_last) begin
        last_x_q    <= tx_q;
        last_y_q    <= ty_q;
        have_last_q <= 1'b1;
      end
    end
  end

  stroke_interpolator_line_stepper u_stepper (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .single_i  (single),
    .step_i    (step),
    .start_x_i (last_x_q),
    .start_y_i (last_y_q),
    .tgt_x_i   (tx_q),
    .tgt_y_i   (ty_q),
    .x_o       (stp_x),
    .y_o       (stp_y),
    .done_o    (stp_done)
  );

  assign bus.pt_valid = pt_valid;
  assign bus.pt_x     = stp_x;
  assign bus.pt_y     = stp_y;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.dropped  = dropped_q;
endmodule

// File: tb/tb_stroke_interpolator.sv
// Directed and randomized stimulus for stroke_interpolator against a queue-based line model.
module tb_stroke_interpolator;
  import stroke_interpolator_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stroke_interpolator_if bus ();
  stroke_interpolator dut (.clk(clk), .reset(reset), .bus(bus));

  int exp_q[$];
  int got_q[$];
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int m_have = 0, m_lx = 0, m_ly = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected stroke for a new sample, as a list of x*1024+y; also advances the remembered last point.
  task automatic model_sample(input int tx, input int ty);
    int adx, ady, x, y, err, e2, ddx, ddy, sx, sy;
    exp_q.delete();
    if (tx >= H_RES || ty >= V_RES) begin
      m_have = 0;
      return;
    end
    adx = iabs(tx - m_lx);
    ady = iabs(ty - m_ly);
`ifdef STROKE_DEADBAND_EN
    if (m_have != 0 && adx <= 1 && ady <= 1) return;
`endif
    if (m_have == 0 || adx > MAX_JUMP || ady > MAX_JUMP) begin
      exp_q.push_back(tx * 1024 + ty);
    end else if (adx != 0 || ady != 0) begin
      x = m_lx; y = m_ly; ddx = adx; ddy = -ady; err = ddx + ddy;
      sx = (tx < m_lx) ? -1 : 1;
      sy = (ty < m_ly) ? -1 : 1;
      while (!(x == tx && y == ty)) begin
        e2 = 2 * err;
        if (e2 >= ddy) begin err += ddy; x += sx; end
        if (e2 <= ddx) begin err += ddx; y += sy; end
        exp_q.push_back(x * 1024 + y);
      end
    end
    m_lx = tx; m_ly = ty; m_have = 1;
  endtask

  // Issue one sample and drain its stroke; ready is low on iters [stall_lo,stall_hi), else random at pct%.
  task automatic run(input int tx, input int ty, input int pct, input int stall_lo,
                     input int stall_hi, input int inject_at);
    int iter, last_acc, drops, n;
    logic pv, pr, fin;
    coord_t px, py;
    model_sample(tx, ty);
    got_q.delete();
    @(negedge clk);
    bus.sample = 1'b1;
    bus.x_in   = coord_t'(tx);
    bus.y_in   = coord_t'(ty);
    @(negedge clk);
    iter = 1; last_acc = 0; drops = 0; pv = 1'b0; pr = 1'b0; px = '0; py = '0; fin = 1'b0;
    while (!fin && iter < 400) begin
      if (iter == 1) check("busy_after_sample", bus.busy, 1);
      if (iter == 2) check("first_valid_timing", bus.pt_valid, (exp_q.size() > 0) ? 1 : 0);
      if (bus.dropped) drops++;
      if (pv && !pr) begin
        check("hold_valid", bus.pt_valid, 1);
        check("hold_xy", bus.pt_x * 1024 + bus.pt_y, px * 1024 + py);
      end
      bus.sample = (iter == inject_at);
      bus.x_in   = coord_t'($urandom_range(0, 639));
      bus.y_in   = coord_t'($urandom_range(0, 479));
      if (!bus.busy && iter >= 2) begin
        fin = 1'b1;
      end else begin
        pr = (iter >= stall_lo && iter < stall_hi) ? 1'b0 : ($urandom_range(1, 100) <= pct);
        bus.pt_ready = pr;
        pv = bus.pt_valid; px = bus.pt_x; py = bus.pt_y;
        if (pv && pr) begin
          got_q.push_back(px * 1024 + py);
          last_acc = iter;
        end
        @(negedge clk);
        iter++;
      end
    end
    bus.sample = 1'b0;
    check("stroke_finished", fin, 1);
    check("busy_fall_iter", iter, (exp_q.size() > 0) ? last_acc + 1 : 2);
    if (pct == 100 && stall_hi <= stall_lo) check("throughput", iter, 2 + exp_q.size());
    check("point_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("point_xy", got_q[i], exp_q[i]);
    check("dropped_pulses", drops, (inject_at > 0) ? 1 : 0);
  endtask

  task automatic check_fixed_line();
    int fx[4] = '{101, 102, 103, 104};
    int fy[4] = '{101, 101, 102, 102};
    check("fixed_line_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("fixed_line_xy", got_q[i], fx[i] * 1024 + fy[i]);
  endtask

  initial begin
    int tx, ty;
    bus.sample = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.pt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pt_valid", bus.pt_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_dropped", bus.dropped, 0);
    check("rst_pt_x", bus.pt_x, 0);
    check("rst_pt_y", bus.pt_y, 0);
    reset = 1'b1;

    run(100, 100, 100, 0, 0, 0);
    run(104, 102, 100, 0, 0, 0);
    check_fixed_line();
    run(100, 100, 100, 0, 0, 0);
    run(104, 102, 100, 2, 7, 0);
    check_fixed_line();
    run(0, int'(NO_BLOB), 100, 0, 0, 0);
    run(50, 60, 100, 0, 0, 0);
    run(10, 10, 100, 0, 0, 0);
    run(200, 10, 100, 0, 0, 0);
    run(10, 10, 100, 0, 0, 0);
    run(70, 10, 100, 0, 0, 20);
    run(71, 10, 100, 0, 0, 0);
    run(71, 10, 100, 0, 0, 0);
    run(700, 20, 100, 0, 0, 0);

    // Reset in the middle of a stalled stroke discards it and forgets the last point.
    run(30, 30, 100, 0, 0, 0);
    model_sample(60, 40);
    @(negedge clk);
    bus.sample = 1'b1; bus.x_in = coord_t'(60); bus.y_in = coord_t'(40); bus.pt_ready = 1'b0;
    @(negedge clk);
    bus.sample = 1'b0;
    repeat (3) @(negedge clk);
    check("midstroke_valid", bus.pt_valid, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_have = 0; m_lx = 0; m_ly = 0;
    check("midrst_pt_valid", bus.pt_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_pt_x", bus.pt_x, 0);
    run(35, 35, 100, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      tx = m_lx + $urandom_range(0, 160) - 80;
      ty = m_ly + $urandom_range(0, 160) - 80;
      if (tx < 0) tx = 0;
      if (tx > H_RES - 1) tx = H_RES - 1;
      if (ty < 0) ty = 0;
      if (ty > V_RES - 1) ty = V_RES - 1;
      if ($urandom_range(0, 7) == 0) ty = int'(NO_BLOB);
      if ($urandom_range(0, 7) == 0) tx = 700;
      run(tx, ty, $urandom_range(40, 100), 0, 0, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
